pc_fetch_unit: RTL and testbench

Program-counter and instruction-fetch stage of the single-stage MIPS datapath. Holds the architectural PC, fetches one instruction per handshake from instruction memory, and presents it to the decode/execute path. When that path retires the instruction, the block consumes the branch-taken signal (Branch AND Zero) plus jump controls and computes the next PC.

---
 rtl/mips_pkg.sv | 11 +
 rtl/next_pc_calc.sv | 29 ++
 rtl/pc_fetch_unit.sv | 68 ++++++
 tb/tb_pc_fetch_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS fetch datapath.
package mips_pkg;
   localparam int ADDR_W = 32;
   localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] INSTR_NOP = 32'h0;

   typedef enum logic {
      FETCH,
      HOLD
   } fetch_state_t;
endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: taken branch, then jump, then sequential.
module next_pc_calc
   import mips_pkg::*;
(
   input  logic [ADDR_W-1:0] pc_plus4,
   input  logic              branch_taken,
   input  logic [31:0]       branch_offset,
   input  logic              jump,
   input  logic [25:0]       jump_target,
   output logic [ADDR_W-1:0] next_pc
);

   logic [ADDR_W-1:0] branch_pc;
   logic [ADDR_W-1:0] jump_pc;

   // Word offset scaled to bytes; overflow wraps modulo 2^ADDR_W.
   assign branch_pc = pc_plus4 + (branch_offset << 2);
   assign jump_pc   = {pc_plus4[ADDR_W-1:28], jump_target, 2'b00};

   always_comb begin
      next_pc = pc_plus4;
      if (branch_taken) begin
         next_pc = branch_pc;
      end else if (jump) begin
         next_pc = jump_pc;
      end
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and single-outstanding instruction fetch handshake.
module pc_fetch_unit
   import mips_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
)(
   input  logic              clk,
   input  logic              reset,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   output logic [31:0]       instr,
   output logic              instr_valid,
   input  logic              instr_ready,
   input  logic              branch_taken,
   input  logic [31:0]       branch_offset,
   input  logic              jump,
   input  logic [25:0]       jump_target,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_plus4
);

   fetch_state_t state;
   fetch_state_t state_next;
   logic [ADDR_W-1:0] next_pc;
   logic capture;
   logic retire;

   assign pc_plus4    = pc + 32'd4;
   assign imem_addr   = pc;
   assign imem_req    = (state == FETCH);
   assign instr_valid = (state == HOLD);
   assign capture     = (state == FETCH) && imem_ack;
   assign retire      = (state == HOLD) && instr_ready;

   next_pc_calc u_next_pc (
      .pc_plus4      (pc_plus4),
      .branch_taken  (branch_taken),
      .branch_offset (branch_offset),
      .jump          (jump),
      .jump_target   (jump_target),
      .next_pc       (next_pc)
   );

   always_comb begin
      state_next = state;
      unique case (state)
         FETCH: if (imem_ack)    state_next = HOLD;
         HOLD:  if (instr_ready) state_next = FETCH;
         default: state_next = FETCH;
      endcase
   end

   // Reset outranks any ack or retire landing in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FETCH;
         pc    <= RESET_PC;
         instr <= INSTR_NOP;
      end else begin
         state <= state_next;
         if (capture) instr <= imem_rdata;
         if (retire)  pc    <= next_pc;
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized scoreboard bench for pc_fetch_unit against an arithmetic PC model.
module tb_pc_fetch_unit;
   import mips_pkg::*;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] word;
   } fetch_item_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_offset = 32'h0;
   logic        jump = 1'b0;
   logic [25:0] jump_target = 26'h0;
   logic [31:0] pc;
   logic [31:0] pc_plus4;

   int checks = 0;
   int errors = 0;
   logic [31:0] model_pc = 32'h0;
   fetch_item_t expect_q[$];

   pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk           (clk),
      .reset         (reset),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .instr         (instr),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .branch_taken  (branch_taken),
      .branch_offset (branch_offset),
      .jump          (jump),
      .jump_target   (jump_target),
      .pc            (pc),
      .pc_plus4      (pc_plus4)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%08h expected=%08h at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference next-PC rule, stated with plain arithmetic.
   function automatic logic [31:0] modelNext(input logic [31:0] cur, input logic br, input logic [31:0] off,
                                             input logic jmp, input logic [25:0] tgt);
      logic [31:0] seq;
      seq = cur + 32'd4;
      if (br)  return seq + off * 32'd4;
      if (jmp) return (seq & 32'hF000_0000) | ({6'd0, tgt} * 32'd4);
      return seq;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops one expectation when instr_valid rises and holds it while valid.
   initial begin : monitor
      fetch_item_t cur;
      logic prev_valid;
      prev_valid = 1'b0;
      cur.pc = 32'h0;
      cur.word = 32'h0;
      forever begin
         @(negedge clk);
         if (instr_valid === 1'b1) begin
            if (!prev_valid) begin
               if (expect_q.size() == 0) begin
                  checkOutput("unexpected_valid", 32'd1, 32'd0);
               end else begin
                  cur = expect_q.pop_front();
               end
            end
            checkOutput("hold_instr", instr, cur.word);
            checkOutput("hold_pc", pc, cur.pc);
         end
         prev_valid = (instr_valid === 1'b1);
      end
   end

   // One full fetch + retire with the given delays and retire-time controls.
   task automatic applyStimulus(input int ack_delay, input int ready_delay, input logic br,
                                input logic [31:0] off, input logic jmp, input logic [25:0] tgt);
      logic [31:0] word;
      fetch_item_t item;
      for (int i = 0; i < ack_delay; i++) begin
         imem_ack = 1'b0;
         imem_rdata = $urandom;
         @(negedge clk);
         checkOutput("fetch_req", {31'd0, imem_req}, 32'd1);
         checkOutput("fetch_addr", imem_addr, model_pc);
         checkOutput("fetch_valid", {31'd0, instr_valid}, 32'd0);
         tick();
      end
      word = $urandom;
      imem_ack = 1'b1;
      imem_rdata = word;
      item.pc = model_pc;
      item.word = word;
      expect_q.push_back(item);
      @(negedge clk);
      checkOutput("ack_addr", imem_addr, model_pc);
      checkOutput("ack_pc_plus4", pc_plus4, model_pc + 32'd4);
      tick();
      imem_ack = 1'b0;
      for (int i = 0; i < ready_delay; i++) begin
         instr_ready = 1'b0;
         imem_ack = 1'($urandom_range(0, 1));
         imem_rdata = ~word;
         branch_taken = 1'($urandom_range(0, 1));
         jump = 1'($urandom_range(0, 1));
         branch_offset = $urandom;
         jump_target = 26'($urandom);
         @(negedge clk);
         checkOutput("hold_req", {31'd0, imem_req}, 32'd0);
         tick();
      end
      imem_ack = 1'b0;
      instr_ready = 1'b1;
      branch_taken = br;
      branch_offset = off;
      jump = jmp;
      jump_target = tgt;
      tick();
      instr_ready = 1'b0;
      branch_taken = 1'b0;
      jump = 1'b0;
      model_pc = modelNext(model_pc, br, off, jmp, tgt);
   endtask

   task automatic gotoPc(input logic [31:0] target);
      applyStimulus(0, 0, 1'b1, (target - model_pc - 32'd4) >> 2, 1'b0, 26'h0);
   endtask

   task automatic checkResetState(input string tag);
      @(negedge clk);
      checkOutput({tag, "_pc"}, pc, 32'h0);
      checkOutput({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
      checkOutput({tag, "_instr"}, instr, 32'h0);
      checkOutput({tag, "_req"}, {31'd0, imem_req}, 32'd1);
   endtask

   initial begin : stimulus
      repeat (3) tick();
      reset = 1'b0;
      checkResetState("reset");
      model_pc = 32'h0;

      for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1'b0, 32'h0, 1'b0, 26'h0);
      applyStimulus(3, 0, 1'b0, 32'h0, 1'b0, 26'h0);
      applyStimulus(0, 0, 1'b1, 32'hFFFF_FFFE, 1'b0, 26'h0);
      applyStimulus(0, 0, 1'b1, 32'h7FFF_FFFF, 1'b0, 26'h0);
      gotoPc(32'h4000_0000);
      applyStimulus(0, 0, 1'b1, 32'h0000_0001, 1'b1, 26'h0000100);
      checkOutput("branch_jump_pc", model_pc, 32'h4000_0008);
      gotoPc(32'h4000_0000);
      applyStimulus(0, 5, 1'b0, 32'h0, 1'b1, 26'h0000100);
      checkOutput("jump_pc", model_pc, 32'h4000_0400);
      gotoPc(32'hFFFF_FFFC);
      applyStimulus(1, 1, 1'b0, 32'h0, 1'b0, 26'h0);

      for (int i = 0; i < 30; i++) begin
         applyStimulus($urandom_range(0, 3), $urandom_range(0, 3),
                       ($urandom_range(0, 3) == 0), $urandom,
                       ($urandom_range(0, 3) == 0), 26'($urandom));
      end

      // Reset landing on an ack in FETCH.
      imem_ack = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      imem_ack = 1'b0;
      checkResetState("rst_fetch");
      model_pc = 32'h0;

      // Reset landing on a retire in HOLD.
      applyStimulus(0, 0, 1'b1, 32'h0000_0010, 1'b0, 26'h0);
      imem_ack = 1'b1;
      imem_rdata = 32'hCAFE_F00D;
      item_push(model_pc, 32'hCAFE_F00D);
      tick();
      imem_ack = 1'b0;
      instr_ready = 1'b1;
      jump = 1'b1;
      jump_target = 26'h3FF_FFFF;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      instr_ready = 1'b0;
      jump = 1'b0;
      checkResetState("rst_hold");
      model_pc = 32'h0;

      applyStimulus(0, 0, 1'b0, 32'h0, 1'b0, 26'h0);
      repeat (2) tick();
      checkOutput("queue_drained", expect_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   task automatic item_push(input logic [31:0] p, input logic [31:0] w);
      fetch_item_t item;
      item.pc = p;
      item.word = w;
      expect_q.push_back(item);
   endtask

   initial begin : watchdog
      #200000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
